// File: rtl/vscale_hasti_sram_slave_pkg.sv
// HASTI bus widths, transfer/size/response codes and lane helpers
// shared by the SRAM slave and its storage array.
package vscale_hasti_sram_slave_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic logic [3:0] byte_en(
    input logic [2:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << off;
      HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/vscale_hasti_sram_slave_byte_array.sv
// DEPTH x 32 storage, per-byte synchronous write,
// asynchronous read.
module vscale_sram_byte_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// HASTI SRAM slave: programmable wait states, sub-word writes,
// two-cycle ERROR response for out-of-range or misaligned accesses.
module vscale_hasti_sram_slave
  import vscale_hasti_sram_slave_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  input  logic                         hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] hburst,
  input  logic                         hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  output logic                         hready,
  output logic [HASTI_RESP_WIDTH-1:0]  hresp
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] word_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          write_q;

  logic [31:0]   rel;
  logic          err;
  logic          accept;
  logic [3:0]    be;
  logic [31:0]   rdata;
  logic          unused;

  assign rel = haddr - BASE_ADDR;
  assign unused = ^{hburst, hmastlock, hprot, rel[31:AW+2]};

  always_comb begin
    err = ({1'b0, rel} >= LIMIT)
       || (hsize > HSIZE_WORD)
       || (hsize == HSIZE_HALF && haddr[0])
       || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);
  end

  always_comb begin
    hready = 1'b0;
    hresp  = HRESP_OKAY;
    unique case (state_q)
      S_IDLE:  hready = 1'b1;
      S_WAIT:  hready = 1'b0;
      S_DATA:  hready = 1'b1;
      S_ERR1:  hresp  = HRESP_ERROR;
      S_ERR2: begin
        hready = 1'b1;
        hresp  = HRESP_ERROR;
      end
      default: hready = 1'b1;
    endcase
  end

  assign accept = hready
               && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else cnt_d = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (!accept) begin
          state_d = S_IDLE;
        end else if (err) begin
          state_d = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          cnt_d   = WS_LOAD;
        end else begin
          state_d = S_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      word_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= HSIZE_BYTE;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        word_q  <= rel[AW+1:2];
        off_q   <= rel[1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  // Write commits at the edge closing the data phase, so a
  // back-to-back read of the same word sees the new value.
  assign be = (state_q == S_DATA && write_q)
            ? byte_en(size_q, off_q) : 4'b0000;

  vscale_sram_byte_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .addr  (word_q),
    .we    (be),
    .wdata (hwdata),
    .rdata (rdata)
  );

  assign hrdata = (state_q == S_DATA && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Directed bench: one slave with one wait state, one with none,
// selected onto a shared master drive.
module tb_vscale_hasti_sram_slave;
  import vscale_hasti_sram_slave_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        sel;

  logic [1:0]  htrans0, htrans1;
  logic [31:0] hrdata0, hrdata1, rd;
  logic        hready0, hready1, rdy;
  logic        hresp0, hresp1, rsp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign htrans0 = sel ? HTRANS_IDLE : htrans;
  assign htrans1 = sel ? htrans : HTRANS_IDLE;
  assign rd  = sel ? hrdata1 : hrdata0;
  assign rdy = sel ? hready1 : hready0;
  assign rsp = sel ? hresp1  : hresp0;

  vscale_hasti_sram_slave #(
    .DEPTH (1024), .BASE_ADDR (32'h0), .WAIT_STATES (0)
  ) dut0 (
    .clk (clk), .reset (reset), .haddr (haddr), .hwrite (hwrite),
    .hsize (hsize), .hburst (3'd0), .hmastlock (1'b0),
    .hprot (4'd0), .htrans (htrans0), .hwdata (hwdata),
    .hrdata (hrdata0), .hready (hready0), .hresp (hresp0)
  );

  vscale_hasti_sram_slave #(
    .DEPTH (1024), .BASE_ADDR (32'h0), .WAIT_STATES (1)
  ) dut1 (
    .clk (clk), .reset (reset), .haddr (haddr), .hwrite (hwrite),
    .hsize (hsize), .hburst (3'd0), .hmastlock (1'b0),
    .hprot (4'd0), .htrans (htrans1), .hwdata (hwdata),
    .hrdata (hrdata1), .hready (hready1), .hresp (hresp1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single transfer from an idle bus; checks hready-low count,
  // hresp during the low cycles and the closing data phase.
  task automatic xfer(
    input string       tag,
    input logic        w,
    input logic [31:0] a,
    input logic [2:0]  sz,
    input logic [31:0] wd,
    input logic [31:0] exp_rd,
    input logic        exp_resp,
    input int          exp_waits
  );
    int   n;
    logic lo_resp;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    htrans  = HTRANS_IDLE;
    hwdata  = wd;
    n       = 0;
    lo_resp = exp_resp;
    forever begin
      @(negedge clk);
      if (rdy) break;
      if (n == 0) lo_resp = rsp;
      n++;
      if (n > 20) break;
    end
    check({tag, "_waits"}, n, exp_waits);
    if (n > 0) check({tag, "_lo_resp"}, {31'b0, lo_resp}, {31'b0, exp_resp});
    check({tag, "_resp"}, {31'b0, rsp}, {31'b0, exp_resp});
    check({tag, "_rdata"}, rd, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    reset  = 1'b1;
    sel    = 1'b1;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
    htrans = HTRANS_IDLE;
    hwdata = 32'h0;
    #3;
    check("rst_ready1", {31'b0, hready1}, 32'd1);
    check("rst_resp1",  {31'b0, hresp1},  32'd0);
    check("rst_rdata1", hrdata1, 32'h0);
    check("rst_ready0", {31'b0, hready0}, 32'd1);
    check("rst_rdata0", hrdata0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // one wait state
    xfer("w_word", 1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 32'h0, 0, 1);
    xfer("r_word", 0, 32'h10, HSIZE_WORD, 32'h0, 32'hDEADBEEF, 0, 1);
    xfer("w_init", 1, 32'h10, HSIZE_WORD, 32'h11223344, 32'h0, 0, 1);
    xfer("w_byte", 1, 32'h11, HSIZE_BYTE, 32'h0000AA00, 32'h0, 0, 1);
    xfer("r_byte", 0, 32'h10, HSIZE_WORD, 32'h0, 32'h1122AA44, 0, 1);
    xfer("w_half", 1, 32'h12, HSIZE_HALF, 32'hBEEF0000, 32'h0, 0, 1);
    xfer("r_half", 0, 32'h10, HSIZE_WORD, 32'h0, 32'hBEEFAA44, 0, 1);

    // error responses
    xfer("w_zero", 1, 32'h0, HSIZE_WORD, 32'hCAFEF00D, 32'h0, 0, 1);
    xfer("e_range", 0, 32'h1000, HSIZE_WORD, 32'h0, 32'h0, 1, 1);
    xfer("e_wmis", 1, 32'h2, HSIZE_WORD, 32'h0, 32'h0, 1, 1);
    xfer("e_hmis", 1, 32'h1, HSIZE_HALF, 32'h0, 32'h0, 1, 1);
    xfer("e_size", 1, 32'h0, 3'd3, 32'h0, 32'h0, 1, 1);
    xfer("r_unchg", 0, 32'h0, HSIZE_WORD, 32'h0, 32'hCAFEF00D, 0, 1);

    // IDLE/BUSY produce no transfer
    haddr  = 32'h10;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    hwdata = 32'h0BAD0BAD;
    for (int i = 0; i < 3; i++) begin
      htrans = (i == 1) ? HTRANS_BUSY : HTRANS_IDLE;
      @(negedge clk);
      check($sformatf("idle%0d_ready", i), {31'b0, rdy}, 32'd1);
      check($sformatf("idle%0d_resp", i), {31'b0, rsp}, 32'd0);
      @(posedge clk); #1;
    end
    htrans = HTRANS_IDLE;
    xfer("r_noacc", 0, 32'h10, HSIZE_WORD, 32'h0, 32'hBEEFAA44, 0, 1);

    // reset during a write's wait state discards the write
    xfer("w_prior", 1, 32'h30, HSIZE_WORD, 32'h12345678, 32'h0, 0, 1);
    haddr  = 32'h30;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    htrans = HTRANS_IDLE;
    hwdata = 32'h77;
    check("rst_in_wait", {31'b0, rdy}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_async_rdy", {31'b0, rdy}, 32'd1);
    check("rst_async_resp", {31'b0, rsp}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    xfer("r_prior", 0, 32'h30, HSIZE_WORD, 32'h0, 32'h12345678, 0, 1);

    // zero wait states, pipelined write then read
    sel = 1'b0;
    @(posedge clk); #1;
    haddr  = 32'h20;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    hwdata = 32'h5;
    hwrite = 1'b0;
    @(negedge clk);
    check("b2b_w_ready", {31'b0, rdy}, 32'd1);
    check("b2b_w_rdata", rd, 32'h0);
    @(posedge clk); #1;
    htrans = HTRANS_IDLE;
    @(negedge clk);
    check("b2b_r_ready", {31'b0, rdy}, 32'd1);
    check("b2b_r_rdata", rd, 32'h5);
    check("b2b_r_resp", {31'b0, rsp}, 32'd0);
    @(posedge clk); #1;
    xfer("ws0_read", 0, 32'h20, HSIZE_WORD, 32'h0, 32'h5, 0, 0);
    xfer("ws0_err", 0, 32'h1000, HSIZE_WORD, 32'h0, 32'h0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
